// File: rtl/four_bit_array_multiplier_pkg.sv
// Shared constants for the small unsigned array multiplier.
package mult_pkg;

    // Operand width of the multiplier core
    localparam int MULT_W = 4;

    // Full product width; an unsigned W x W product always fits in 2W bits
    localparam int PROD_W = 2 * MULT_W;

endpackage : mult_pkg

// File: rtl/four_bit_array_multiplier_full_adder.sv
// One-bit full adder cell used to build every row of the multiplier array.
// Half-adder positions reuse this cell with one input tied to zero.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority-carry of the three input bits
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/four_bit_array_multiplier.sv
// Unsigned 4x4 carry-save array multiplier with a registered 8-bit product.
// Partial products are reduced row by row in carry-save form; the last row's
// sums and carries are merged by a ripple-carry row into the upper product bits.
module four_bit_array_multiplier
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MULT_W-1:0] X,
    input  logic [MULT_W-1:0] Y,
    output logic [PROD_W-1:0] Z
);

    // pp[i][j] = X[j] & Y[i]; row i carries weight 2^i
    logic [MULT_W-1:0] pp        [MULT_W];

    // Carry-save state per row: row_sum[i][j] has weight 2^(i+j),
    // row_carry[i][j] has weight 2^(i+j+1)
    logic [MULT_W-1:0] row_sum   [MULT_W];
    logic [MULT_W-1:0] row_carry [MULT_W];

    // Final ripple row: merges the last row's remaining sums and carries
    logic [MULT_W-1:0] final_b;
    logic [MULT_W-1:0] final_sum;
    logic [MULT_W:0]   ripple_carry;
    logic              ripple_unused;

    logic [PROD_W-1:0] z_d;
    logic [PROD_W-1:0] z_q;

    // Partial-product AND plane
    for (genvar i = 0; i < MULT_W; i++) begin : g_pp_row
        for (genvar j = 0; j < MULT_W; j++) begin : g_pp_col
            assign pp[i][j] = X[j] & Y[i];
        end
    end

    // Row 0 is the first partial product itself with no carries yet
    assign row_sum[0]   = pp[0];
    assign row_carry[0] = '0;

    // Rows 1..3: add pp[i] to the previous row's sums shifted down one column
    // plus its carries. In row 1 every carry input is zero and in the top
    // column of each row the shifted-sum input is zero, so those cells act as
    // half adders.
    for (genvar i = 1; i < MULT_W; i++) begin : g_row
        logic [MULT_W-1:0] shifted_sum;
        assign shifted_sum = {1'b0, row_sum[i-1][MULT_W-1:1]};

        for (genvar j = 0; j < MULT_W; j++) begin : g_cell
            full_adder u_fa (
                .a    (pp[i][j]),
                .b    (shifted_sum[j]),
                .cin  (row_carry[i-1][j]),
                .sum  (row_sum[i][j]),
                .cout (row_carry[i][j])
            );
        end
    end

    // Final ripple row: upper product bits from the last row's sums and carries.
    // The first cell has no incoming ripple carry, so it is a half adder.
    assign final_b         = {1'b0, row_sum[MULT_W-1][MULT_W-1:1]};
    assign ripple_carry[0] = 1'b0;

    for (genvar j = 0; j < MULT_W; j++) begin : g_ripple
        full_adder u_fa (
            .a    (final_b[j]),
            .b    (row_carry[MULT_W-1][j]),
            .cin  (ripple_carry[j]),
            .sum  (final_sum[j]),
            .cout (ripple_carry[j+1])
        );
    end

    // The carry out of the top ripple cell is always zero (15*15 fits in 8 bits)
    assign ripple_unused = ripple_carry[MULT_W];

    // Assemble the combinational product: row LSBs form the low bits
    always_comb begin
        z_d = '0;
        for (int i = 0; i < MULT_W; i++) begin
            z_d[i] = row_sum[i][0];
        end
        z_d[PROD_W-1:MULT_W] = final_sum;
    end

    // Output register, cleared immediately whenever reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end

    assign Z = z_q;

endmodule : four_bit_array_multiplier

// File: tb/tb_four_bit_array_multiplier.sv
// Self-checking bench for the registered 4x4 array multiplier.
module tb_four_bit_array_multiplier;

    import mult_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [MULT_W-1:0] X;
    logic [MULT_W-1:0] Y;
    logic [PROD_W-1:0] Z;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [PROD_W-1:0] expectedQ [$];
    logic [PROD_W-1:0] lastExpected = '0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    four_bit_array_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (X),
        .Y     (Y),
        .Z     (Z)
    );

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [PROD_W-1:0] actual,
                               input logic [PROD_W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    // Drive one operand pair, queue its product, clock it in and check it
    task automatic applyStimulus(input logic [MULT_W-1:0] x, input logic [MULT_W-1:0] y,
                                 input string tag);
        logic [PROD_W-1:0] e;
        X = x;
        Y = y;
        e = PROD_W'(int'(x) * int'(y));
        expectedQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (expectedQ.size() == 0) begin
            checkOutput({tag, "_noExpected"}, Z, 8'hxx);
        end else begin
            e = expectedQ.pop_front();
            checkOutput(tag, Z, e);
            lastExpected = e;
        end
    endtask

    // Pulse reset between edges and check the asynchronous clear
    task automatic midReset();
        rst_n = 1'b0;
        #1;
        checkOutput("midReset", Z, 8'h00);
        #1;
        rst_n = 1'b1;
        lastExpected = '0;
    endtask

    // Main sequence
    initial begin
        rst_n = 1'b1;
        X     = 4'hF;
        Y     = 4'hF;

        // Asynchronous reset with no clock edge, then hold across an edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("resetAsync", Z, 8'h00);
        @(posedge clk);
        @(negedge clk);
        checkOutput("resetHold", Z, 8'h00);
        rst_n = 1'b1;
        applyStimulus(4'hF, 4'hF, "resetRelease");

        // Corner operands
        applyStimulus(4'd0,  4'd9,  "zeroTimesNine");
        applyStimulus(4'd1,  4'd13, "oneTimes13");
        applyStimulus(4'd15, 4'd1,  "fifteenTimesOne");
        applyStimulus(4'd15, 4'd15, "maxTimesMax");

        // Long carry chains
        applyStimulus(4'b1011, 4'b0111, "carry77");
        applyStimulus(4'b1110, 4'b1101, "carry182");

        // Exhaustive sweep, one pair per clock, with a reset pulse part-way
        for (int xv = 0; xv < 16; xv++) begin
            for (int yv = 0; yv < 16; yv++) begin
                applyStimulus(4'(xv), 4'(yv), $sformatf("sweep_%0dx%0d", xv, yv));
                if (xv == 9 && yv == 4) begin
                    midReset();
                end
            end
        end

        // Operands changing twice between edges must not disturb Z
        X = 4'd3;
        Y = 4'd5;
        #1;
        checkOutput("stableFirst", Z, lastExpected);
        X = 4'd6;
        Y = 4'd7;
        #1;
        checkOutput("stableSecond", Z, lastExpected);
        applyStimulus(4'd6, 4'd7, "stableResult");

        checkOutput("queueEmpty", PROD_W'(expectedQ.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_four_bit_array_multiplier
